// File: rtl/m_ext_divider.sv
// m_ext_divider: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per CALC cycle (XLEN cycles), followed by a
// single FIX cycle that applies the result sign, then a one-cycle DONE.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module m_ext_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [4:0]      ALUControl,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Kill,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b11001;
  localparam logic [4:0] OP_REMU = 5'b11101;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] rem;        // partial remainder
  logic [XLEN-1:0] quo;        // dividend shifting out / quotient shifting in
  logic [XLEN-1:0] dvs;        // divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic            want_rem;
  logic            neg_q;
  logic            neg_r;

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic            op_valid;
  logic            op_signed;
  logic            op_rem;
  logic            div_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] fix_res;

  // Two's-complement magnitude when the operand is treated as signed.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude for the iteration.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                               input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  // Re-apply the sign removed before iterating (wraps at XLEN bits).
  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? -v : v;
  endfunction

  // Operation decode, special-case detection and one restoring step.
  always_comb begin
    a_s         = A;
    b_s         = B;
    op_valid    = 1'b0;
    op_signed   = 1'b0;
    op_rem      = 1'b0;
    case (ALUControl)
      OP_DIV:  begin op_valid = 1'b1; op_signed = 1'b1; op_rem = 1'b0; end
      OP_DIVU: begin op_valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; end
      OP_REM:  begin op_valid = 1'b1; op_signed = 1'b1; op_rem = 1'b1; end
      OP_REMU: begin op_valid = 1'b1; op_signed = 1'b0; op_rem = 1'b1; end
      default: begin op_valid = 1'b0; op_signed = 1'b0; op_rem = 1'b0; end
    endcase

    a_mag    = magnitude(A, op_signed);
    b_mag    = magnitude(B, op_signed);
    div_zero = (B == '0);
    sgn_ovf  = op_signed && (A == MOST_NEG) && (b_s == -1);
    special  = div_zero || sgn_ovf;

    // x/0: quotient all ones, remainder is the dividend untouched.
    // MIN/-1: quotient is the dividend, remainder zero.
    if (div_zero) begin
      special_res = op_rem ? A : '1;
    end else begin
      special_res = op_rem ? '0 : A;
    end

    // Shift the next dividend bit into the remainder and try subtracting.
    // Since rem < dvs, a non-negative trial always fits in XLEN bits and
    // a negative one always sets the top bit.
    rem_sh  = {rem, quo[XLEN-1]};
    trial   = rem_sh - {1'b0, dvs};

    fix_res = want_rem ? apply_sign(rem, neg_r) : apply_sign(quo, neg_q);
  end

  // Divider FSM with registered Busy/Done/Result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= '0;
    end else if (Kill) begin
      // Abort outranks any new request; Result keeps its old value.
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
          if (Start && op_valid) begin
            want_rem <= op_rem;
            neg_q    <= op_signed && (a_s[XLEN-1] ^ b_s[XLEN-1]);
            neg_r    <= op_signed && a_s[XLEN-1];
            if (special) begin
              Result <= special_res;
              state  <= DONE;
              Done   <= 1'b1;
            end else begin
              rem   <= '0;
              quo   <= a_mag;
              dvs   <= b_mag;
              cnt   <= CNT_W'(XLEN - 1);
              state <= CALC;
              Busy  <= 1'b1;
            end
          end
        end

        CALC: begin
          if (trial[XLEN]) begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end else begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end

        FIX: begin
          Result <= fix_res;
          state  <= DONE;
          Busy   <= 1'b0;
          Done   <= 1'b1;
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_ext_divider.sv
// Testbench for m_ext_divider: scoreboard of expected results and completion
// cycles, checked by an independent monitor whenever Done is seen.
module tb_m_ext_divider;
  localparam int XLEN = 32;

  localparam logic [4:0] C_DIV  = 5'b10001;
  localparam logic [4:0] C_DIVU = 5'b10101;
  localparam logic [4:0] C_REM  = 5'b11001;
  localparam logic [4:0] C_REMU = 5'b11101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  ALUControl = 5'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Kill = 1'b0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  m_ext_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Kill(Kill), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          op_id = 0;
  logic [31:0] last_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit is_valid(input logic [4:0] op);
    return op == C_DIV || op == C_DIVU || op == C_REM || op == C_REMU;
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (op == C_DIV || op == C_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    bit want_rem;
    sgn      = (op == C_DIV || op == C_REM);
    want_rem = (op == C_REM || op == C_REMU);
    if (b == 0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'h0 : a;
    if (sgn) return want_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return want_rem ? a % b : a / b;
  endfunction

  // Monitor: pops on every Done, otherwise Result must hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_result = '0;
    end else if (Done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=0x%08h required=no_done", Result);
      end else begin
        e = sb.pop_front();
        check($sformatf("result_op%0d", e.id), Result, e.res);
        check_int($sformatf("latency_op%0d", e.id), cyc, e.due);
        last_result = e.res;
      end
    end else begin
      check("result_hold", Result, last_result);
    end
  end

  // Called at a negedge; waits for a free divider, drives Start for one cycle.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit use_model);
    int   guard;
    bit   sp;
    exp_t e;
    guard = 0;
    while (Busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
    sp = is_special(op, a, b);
    Start = 1'b1;
    ALUControl = op;
    A = a;
    B = b;
    if (is_valid(op)) begin
      e.res = use_model ? ref_model(op, a, b) : exp_res;
      e.due = cyc + 1 + (sp ? 0 : XLEN + 1);
      e.id  = op_id;
      op_id++;
      sb.push_back(e);
    end
    @(negedge clk);
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    ALUControl = 5'($urandom);
    if (is_valid(op)) check("busy_after_accept", {31'b0, Busy}, {31'b0, !sp});
    else check("busy_invalid_op", {31'b0, Busy}, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      4:       return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [4];
    int guard;
    ops[0] = C_DIV; ops[1] = C_DIVU; ops[2] = C_REM; ops[3] = C_REMU;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, Busy}, 32'h0);
    check("reset_done", {31'b0, Done}, 32'h0);
    check("reset_result", Result, 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Directed operations (second of each pair is issued in the DONE cycle)
    issue(C_DIV,  32'd100, 32'd7, 32'd14, 0);
    issue(C_REM,  32'd100, 32'd7, 32'd2, 0);
    issue(C_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    issue(C_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    issue(C_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0);
    issue(C_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 0);
    issue(C_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    issue(C_REMU, 32'd5, 32'd0, 32'd5, 0);
    issue(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    issue(C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    issue(C_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    issue(C_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    repeat (40) @(negedge clk);

    // Unrecognised code is ignored
    issue(5'b00000, 32'd9, 32'd3, 32'd0, 0);
    repeat (5) @(negedge clk);

    // Ignored restart while busy, then Kill
    issue(C_DIVU, 32'd100, 32'd7, 32'd14, 0);
    repeat (3) @(negedge clk);
    Start = 1'b1; ALUControl = C_DIVU; A = 32'd9; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Kill = 1'b1;
    @(negedge clk);
    Kill = 1'b0;
    check("kill_busy", {31'b0, Busy}, 32'h0);
    check("kill_done", {31'b0, Done}, 32'h0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    repeat (40) @(negedge clk);
    issue(C_DIVU, 32'd9, 32'd3, 32'd3, 0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of CALC
    issue(C_DIV, 32'd1000, 32'd3, 32'd333, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midcalc_reset_busy", {31'b0, Busy}, 32'h0);
    check("midcalc_reset_done", {31'b0, Done}, 32'h0);
    check("midcalc_reset_result", Result, 32'h0);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // Random sweep against the reference model
    for (int i = 0; i < 120; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 19) == 0) ? 5'b10000 : ops[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, pick(), pick(), 32'h0, 1);
    end

    // Drain
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_int("drain_pending", sb.size(), 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
